aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Iterative AES-128 inverse key schedule for the decryption datapath. Accepts the final round key (round 10) and emits round keys 10, 9, …, 0 on a valid/ready stream, one per cycle, deriving each previous key by running the expansion recurrence backward. It feeds the inverse-cipher round logic, so a full forward expansion pass before decryption is unnecessary.

## Interface
- No parameters. AES-128 only; the key width is fixed at 128.
- `clk` in 1: the single clock. Every register updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: `load_key` is presented.
- `load_ready` out 1: the block accepts a load. High only in IDLE.
- `load_key` in 128: round-10 key. Word k0 = [127:96] and k3 = [31:0]. Byte 0 of each word sits in the word's MSBs.
- `out_valid` out 1: `out_key` and `out_round` are valid.
- `out_ready` in 1: the consumer accepts the current key.
- `out_key` out 128: the current round key, in the same packing as `load_key`.
- `out_round` out 4: the round index of `out_key`, from 10 down to 0.

## Operation
- FSM states are IDLE and EMIT.
- **IDLE**
  - `load_ready`=1 and `out_valid`=0.
  - When `load_valid`=1: capture `load_key` into the key register, set round to 10, and go to EMIT.
- **EMIT**
  - `out_valid`=1, and `out_key`/`out_round` come straight from registers.
  - On an output handshake (`out_valid`&`out_ready`):
    - If round>0: the key register takes prev(key, round), round decrements, and the state stays EMIT.
    - If round==0: go to IDLE.
- **prev(K, r)**: with K=(k0,k1,k2,k3), compute:
  - p3 = k3^k2
  - p2 = k2^k1
  - p1 = k1^k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - RotWord rotates left by one byte: {b0,b1,b2,b3} becomes {b1,b2,b3,b0}.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Rcon is indexed by the round being left: 10 → 9 uses 36.
- prev() is purely combinational from the registered key. No S-box result is registered.
- `load_valid` while not IDLE is ignored. No error is flagged, and the in-progress sequence is unaffected.
- `out_ready` low stalls the block. Key, round and `out_valid` hold indefinitely.
- **Reset:** state IDLE, key register 0, round 0. Therefore `out_valid`=0, `out_key`=0, `out_round`=0 and `load_ready`=1.
- Reset mid-sequence aborts the sequence immediately. No partial key is emitted.

## Timing
- A load handshake in cycle T gives `out_valid`=1 with round 10 (the loaded key, unchanged) in cycle T+1.
- With `out_ready` held high, rounds 10…0 appear in cycles T+1…T+11, with no bubbles.
- The round-0 handshake at cycle T+11 gives `load_ready`=1 in cycle T+12. Back-to-back loads therefore cost one idle cycle.
- There is no combinational path from `load_valid` or `out_ready` to any output.

## Configuration
- **`AES_INV_KEY_SCHED_ABORT_EN` defined:**
  - Adds input `abort` (1 bit).
  - `abort`=1 in any state forces IDLE on the next edge. `out_valid` falls in that cycle and the key register and round are zeroed.
  - `abort` has priority over a simultaneous load or output handshake.
- **Macro undefined:** the `abort` port is absent and only reset ends a sequence.

## Structure
- Shared package `aes_pkg` holds:
  - the Rcon constant array;
  - a `round_key_t` 128-bit typedef;
  - `AES_ROUNDS` = 10;
  - the state enum (IDLE, EMIT).
- Sub-module `aes_sub_word`: 32-bit in, 32-bit out, built from four instances of the team's existing byte S-box lookup. It is instantiated once, on RotWord(p3).

## Test plan
- **FIPS-197 A.1 sequence:**
  - Load d014f9a8c9ee2589e13f0cc8b6630ca6 with `out_ready`=1.
  - Round 10 shows the loaded key.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c, at cycle T+11.
  - `load_ready` is back to 1 at T+12.
- **Backpressure:**
  - Same load, with `out_ready` low for 5 cycles at round 9.
  - `out_key` holds ac7766f3… and `out_round`=9 throughout.
  - The sequence resumes unchanged.
- **Load while busy:**
  - Assert `load_valid` with key all-0 during round 5.
  - Expect `load_ready`=0 and all 11 outputs matching the A.1 reference.
- **Async reset mid-sequence:**
  - Drop `rst_n` at round 6, mid-cycle.
  - `out_valid`, `out_key` and `out_round` go to 0 without waiting for a clock edge, and `load_ready`=1.
  - A fresh load then runs the full sequence correctly.
- **Abort (macro defined):**
  - Assert `abort` at round 3 while `out_ready`=1.
  - Next cycle: `out_valid`=0, `out_key`=0, state IDLE.
- **Round-0 wrap:**
  - Hold `out_ready` low at round 0.
  - The block stays in EMIT with round 0 and never wraps to 15.
  - `out_ready` rising gives IDLE next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// ==========================================================================
// aes_pkg : shared AES-128 key-schedule types, constants and helpers
// Rev 1.0
// ==========================================================================
`default_nettype none

package aes_pkg;

  typedef logic [127:0] round_key_t;

  localparam logic [3:0] AES_ROUNDS = 4'd10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Indexed by the round being left; unused slots are zero so any 4-bit index is safe.
  localparam logic [7:0] c_rcon [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ==========================================================================
// aes_sbox : forward AES byte substitution, purely combinational lookup
// Rev 1.0
// ==========================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  // Entry 0x00 occupies the top byte, so the slice offset is the inverted index.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_out = c_sbox[{~sbox_in, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/aes_sub_word.sv
// ==========================================================================
// aes_sub_word : SubWord over a 32-bit word, four parallel byte S-boxes
// Rev 1.0
// ==========================================================================
`default_nettype none

module aes_sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .sbox_in  (word_in[8*b +: 8]),
      .sbox_out (word_out[8*b +: 8])
    );
  end

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// ==========================================================================
// aes_inv_key_sched : iterative AES-128 inverse key schedule, keys 10..0
// Optional abort input under AES_INV_KEY_SCHED_ABORT_EN.  Rev 1.0
// ==========================================================================
`default_nettype none

module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_KEY_SCHED_ABORT_EN
  input  logic         abort,
`endif
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [127:0] load_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round
);

  state_e     state_q, state_d;
  round_key_t key_q,   key_d;
  logic [3:0] round_q, round_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_rot_p3;
  round_key_t  prev_key;

  assign {k0, k1, k2, k3} = key_q;

  // Backward expansion: the three trailing words are plain XOR differences,
  // only the leading word needs the S-box path.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  aes_sub_word u_sub_word (
    .word_in  (rot_word(p3)),
    .word_out (sub_rot_p3)
  );

  assign p0       = k0 ^ sub_rot_p3 ^ {c_rcon[round_q], 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          key_d   = load_key;
          round_d = AES_ROUNDS;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    if (abort) begin
      state_d = IDLE;
      key_d   = '0;
      round_d = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign out_key    = key_q;
  assign out_round  = round_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
// ==========================================================================
// tb_aes_inv_key_sched : randomized self-checking bench with FIPS-197 model
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_inv_key_sched;

  typedef logic [127:0] key_arr_t [0:10];

  localparam logic [127:0] c_a1_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_a1_r9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] c_a1_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_a1_r0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load_valid = 1'b0;
  logic [127:0] load_key = '0;
  logic         out_ready = 1'b0;
  logic         load_ready;
  logic         out_valid;
  logic [127:0] out_key;
  logic [3:0]   out_round;
`ifdef AES_INV_KEY_SCHED_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_key   (load_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_key    (out_key),
    .out_round  (out_round)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: GF(2^8) arithmetic + FIPS-197 words ----
  logic [7:0] sbox_m [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_m(input int r);
    logic [7:0] v = 8'h01;
    for (int i = 1; i < r; i++) v = xtime(v);
    return v;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r = {w[23:0], w[31:24]};
    return {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]};
  endfunction

  // Invert w[i] = w[i-4] ^ temp(w[i-1]) from the last four words down to w[0].
  task automatic expand_back(input logic [127:0] k10, output key_arr_t ks);
    logic [31:0] w [0:43];
    for (int j = 0; j < 4; j++) w[40 + j] = k10[127 - 32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      logic [31:0] t = w[i + 3];
      if ((i + 4) % 4 == 0) t = sub_rot(t) ^ {rcon_m((i + 4) / 4), 24'h0};
      w[i] = w[i + 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Protocol-level model of what the block must be presenting.
  logic     m_busy = 1'b0;
  int       m_round = 0;
  logic     m_zero = 1'b1;
  key_arr_t m_keys;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_round = 0; m_zero = 1'b1;
    end
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    else if (abort) begin
      m_busy = 1'b0; m_round = 0; m_zero = 1'b1;
    end
`endif
    else if (!m_busy) begin
      if (load_valid) begin
        expand_back(load_key, m_keys);
        m_busy = 1'b1; m_round = 10; m_zero = 1'b0;
      end
    end else if (out_ready) begin
      if (m_round == 0) m_busy = 1'b0;
      else m_round = m_round - 1;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 128'(out_valid), 128'(m_busy));
    chk("load_ready", 128'(load_ready), 128'(!m_busy));
    if (m_busy) begin
      chk("out_round", 128'(out_round), 128'(m_round));
      chk("out_key", out_key, m_keys[m_round]);
    end else if (m_zero) begin
      chk("idle_round", 128'(out_round), 128'd0);
      chk("idle_key", out_key, 128'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    step();
    load_valid = 1'b1;
    load_key   = k;
    step();
    load_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    key_arr_t ks;
    build_sbox();
    expand_back(c_a1_r10, ks);
    chk("model_r9", ks[9], c_a1_r9);
    chk("model_r1", ks[1], c_a1_r1);
    chk("model_r0", ks[0], c_a1_r0);

    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_key", out_key, 128'd0);
    chk("rst_load_ready", 128'(load_ready), 128'd1);
    rst_n = 1'b1;

    // FIPS-197 A.1 sequence, no backpressure
    out_ready = 1'b1;
    load(c_a1_r10);
    chk("a1_r10", out_key, c_a1_r10);
    step();
    chk("a1_r9", out_key, c_a1_r9);
    repeat (8) step();
    chk("a1_r1_round", 128'(out_round), 128'd1);
    chk("a1_r1", out_key, c_a1_r1);
    step();
    chk("a1_r0", out_key, c_a1_r0);
    step();
    chk("a1_done_ready", 128'(load_ready), 128'd1);

    // Backpressure at round 9
    load(c_a1_r10);
    step();
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_round", 128'(out_round), 128'd9);
      chk("bp_key", out_key, c_a1_r9);
    end
    out_ready = 1'b1;
    repeat (10) step();
    chk("bp_done_ready", 128'(load_ready), 128'd1);

    // Load attempt while busy is ignored
    load(c_a1_r10);
    repeat (5) step();
    load_valid = 1'b1;
    load_key   = '0;
    step();
    chk("busy_load_ready", 128'(load_ready), 128'd0);
    step();
    load_valid = 1'b0;
    repeat (5) step();

    // Asynchronous reset in the middle of round 6
    load(rand_key());
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_key", out_key, 128'd0);
    chk("arst_round", 128'(out_round), 128'd0);
    chk("arst_ready", 128'(load_ready), 128'd1);
    step();
    rst_n = 1'b1;
    load(c_a1_r10);
    repeat (10) step();
    chk("arst_rerun_r0", out_key, c_a1_r0);
    step();

    // Stall at round 0 must not wrap
    load(c_a1_r10);
    repeat (10) step();
    out_ready = 1'b0;
    repeat (4) begin
      step();
      chk("r0_hold_round", 128'(out_round), 128'd0);
      chk("r0_hold_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    step();
    chk("r0_exit_valid", 128'(out_valid), 128'd0);
    chk("r0_exit_ready", 128'(load_ready), 128'd1);

`ifdef AES_INV_KEY_SCHED_ABORT_EN
    load(c_a1_r10);
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 128'(out_valid), 128'd0);
    chk("abort_key", out_key, 128'd0);
    chk("abort_round", 128'(out_round), 128'd0);
    chk("abort_ready", 128'(load_ready), 128'd1);
`endif

    // Randomized traffic against the model
    repeat (600) begin
      step();
      out_ready  = ($urandom_range(0, 3) != 0);
      load_valid = ($urandom_range(0, 4) == 0);
      load_key   = rand_key();
`ifdef AES_INV_KEY_SCHED_ABORT_EN
      abort      = ($urandom_range(0, 40) == 0);
`endif
    end
    load_valid = 1'b0;
    out_ready  = 1'b1;
`ifdef AES_INV_KEY_SCHED_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (15) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
